// File: rtl/btn_pkg.sv
// Shared definitions for the multi-button event controller:
// event kind encodings, scanner state encoding and a width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_LONG    = 2'b11
  } ev_kind_t;

  typedef enum logic {
    SC_IDLE = 1'b0,
    SC_SCAN = 1'b1
  } sc_state_t;

  // Width of a button index; a single button still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..DIV-1 and asserts tick for the single
// cycle in which the count sits at DIV-1, then wraps to 0.
module tick_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  // Wrap the counter at DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == CW'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-button front end: synchronizes N_BTN raw inputs, scans one button per
// cycle after each shared sample tick, filters bounces, tracks filtered state
// and queues press/release (and optionally long-press) events into per-button
// pending slots that a round-robin arbiter drains onto one valid/ready port.
// Optional feature: define BTN_LONG_PRESS_EN to build the hold counters and
// long-press events; without it LONG_TICKS is ignored.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4,
  parameter int LONG_TICKS = 200,
  localparam int IW        = idx_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [IW-1:0]    event_btn,
  output logic [1:0]       event_kind,
  output logic             overflow
);

  logic [N_BTN-1:0] sync1, sync2, snap;
  logic             tick;
  sc_state_t        state, state_nxt;
  logic             scan_en, snap_load, scan_last;
  logic [IW-1:0]    idx;
  logic [3:0]       cnt [N_BTN];
  logic [N_BTN-1:0] pend;
  ev_kind_t         pend_kind [N_BTN];
  logic [IW-1:0]    rr_ptr;

  logic             cur_snap, cur_state, flip, raise;
  ev_kind_t         raise_kind;
  logic [3:0]       cnt_inc;
  logic             arb_free, found, gnt;
  logic [IW-1:0]    gnt_idx;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hold [N_BTN];
  logic [HW-1:0] hold_inc;
  logic          long_hit;
`endif

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer on every raw button level.
  // NOTE: non-blocking assignments let sync2 take the old sync1, forming a real two-stage chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Scanner state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SC_IDLE;
    else      state <= state_nxt;
  end

  assign scan_last = (idx == IW'(N_BTN - 1));

  // Scanner next state: start on tick, stop after the last button.
  always_comb begin
    state_nxt = state;
    case (state)
      SC_IDLE: if (tick)      state_nxt = SC_SCAN;
      SC_SCAN: if (scan_last) state_nxt = SC_IDLE;
      default:                state_nxt = SC_IDLE;
    endcase
  end

  // Scanner outputs.
  always_comb begin
    scan_en   = (state == SC_SCAN);
    snap_load = (state == SC_IDLE) && tick;
  end

  // Freeze the synchronized inputs for the whole scan and walk the index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      snap <= '0;
    end else if (snap_load) begin
      idx  <= '0;
      snap <= sync2;
    end else if (scan_en) begin
      idx <= scan_last ? '0 : idx + 1'b1;
    end
  end

  // Decide what happens to the button under the scan index this cycle.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    cur_snap   = snap[idx];
    cur_state  = btn_state[idx];
    cnt_inc    = cnt[idx] + 4'd1;
    flip       = scan_en && (cur_snap != cur_state) && (cnt_inc == 4'(STABLE_CNT));
    raise      = flip;
    raise_kind = cur_state ? EV_RELEASE : EV_PRESS;
`ifdef BTN_LONG_PRESS_EN
    hold_inc   = hold[idx] + 1'b1;
    long_hit   = scan_en && cur_state && !flip &&
                 (hold[idx] != HW'(LONG_TICKS)) && (hold_inc == HW'(LONG_TICKS));
    if (long_hit) begin
      raise      = 1'b1;
      raise_kind = EV_LONG;
    end
`endif
  end

  // Stability counters and filtered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_state <= '0;
      // NOTE: the counter array is reset element by element so a reset mid-bounce starts clean.
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else if (scan_en) begin
      if (cur_snap == cur_state) begin
        cnt[idx] <= '0;
      end else if (flip) begin
        cnt[idx]       <= '0;
        btn_state[idx] <= ~cur_state;
      end else begin
        cnt[idx] <= cnt_inc;
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  // Pressed-sample counters, saturating at LONG_TICKS so only one long event fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) hold[i] <= '0;
    end else if (scan_en) begin
      if (flip) begin
        hold[idx] <= '0;
      end else if (cur_state && (hold[idx] != HW'(LONG_TICKS))) begin
        hold[idx] <= hold_inc;
      end
    end
  end
`endif

  // Round-robin search for the first pending slot after the last grant.
  always_comb begin
    int j;
    j        = 0;
    arb_free = !event_valid || event_ready;
    found    = 1'b0;
    gnt_idx  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!found && pend[IW'(j)]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    gnt = found && arb_free;
  end

  // Pending slots; a new event written while the grant takes the old one stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < N_BTN; i++) pend_kind[i] <= EV_NONE;
    end else begin
      if (gnt) pend[gnt_idx] <= 1'b0;
      if (raise) begin
        pend[idx]      <= 1'b1;
        pend_kind[idx] <= raise_kind;
        if (pend[idx] && !(gnt && (gnt_idx == idx))) overflow <= 1'b1;
      end
    end
  end

  // Output event register and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_valid <= 1'b0;
      event_btn   <= '0;
      event_kind  <= EV_NONE;
      rr_ptr      <= '0;
    end else if (arb_free) begin
      event_valid <= gnt;
      if (gnt) begin
        event_btn  <= gnt_idx;
        event_kind <= pend_kind[gnt_idx];
        rr_ptr     <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: a sample-level reference model pushes
// expected events into a scoreboard; a monitor pops and compares on transfers.
`timescale 1ns/1ps
module tb_btn_event_ctrl;
  import btn_pkg::*;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int STB  = 3;
  localparam int LONG = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_state;
  logic       event_valid;
  logic       event_ready = 1'b1;
  logic [1:0] event_btn;
  logic [1:0] event_kind;
  logic       overflow;

  btn_event_ctrl #(
    .N_BTN      (N),
    .TICK_DIV   (DIV),
    .STABLE_CNT (STB),
    .LONG_TICKS (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_state   (btn_state),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_btn   (event_btn),
    .event_kind  (event_kind),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int btn;
    int kind;
  } ev_t;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];
  ev_t seen_q[$];
  int  valid_cycles = 0;
  int  long_seen    = 0;

  // Reference model: one entry per button, updated once per sample.
  bit m_state[N];
  int m_run[N];
  int m_held[N];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 1'b0;
      m_run[i]   = 0;
      m_held[i]  = 0;
    end
    exp_q.delete();
  endtask

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_state[i];
    return v;
  endfunction

  // Apply one sample to every button in index order.
  task automatic model_sample(input logic [3:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i] != m_state[i]) begin
        m_run[i]++;
        if (m_run[i] == STB) begin
          m_state[i] = !m_state[i];
          m_run[i]   = 0;
          m_held[i]  = 0;
          exp_q.push_back('{i, m_state[i] ? 1 : 2});
          continue;
        end
      end else begin
        m_run[i] = 0;
      end
`ifdef BTN_LONG_PRESS_EN
      if (m_state[i] && m_held[i] < LONG) begin
        m_held[i]++;
        if (m_held[i] == LONG) exp_q.push_back('{i, 3});
      end
`endif
    end
  endtask

  // One sample period. Starts just after a sampling edge (or reset release);
  // the DUT captures v on the last edge of the period. mode: 0 ready high,
  // 1 ready low, 2 ready random early in the period and high afterwards.
  task automatic run_period(input logic [3:0] v, input int mode);
    btn_in = v;
    for (int p = 1; p <= DIV; p++) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       event_ready = 1'b1;
        1:       event_ready = 1'b0;
        default: event_ready = (p <= 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
      endcase
      if (p == 5) check("btn_state", int'(btn_state), int'(model_vec()));
      if (p == DIV) model_sample(v);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard and checks that a
  // stalled event keeps its payload.
  logic       prev_stall = 1'b0;
  logic [1:0] prev_btn, prev_kind;
  always @(negedge clk) begin
    int fi;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(event_valid), 1);
        check("stall_btn", int'(event_btn), int'(prev_btn));
        check("stall_kind", int'(event_kind), int'(prev_kind));
      end
      if (event_valid) begin
        valid_cycles++;
        check("kind_nonzero", int'(event_kind != 2'b00), 1);
      end
      if (event_valid && event_ready) begin
        fi = -1;
        foreach (exp_q[k]) if (fi < 0 && exp_q[k].btn == int'(event_btn)) fi = k;
        if (fi < 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got btn=%0d kind=%0d, required no event (t=%0t)",
                   event_btn, event_kind, $time);
        end else begin
          check("event_kind", int'(event_kind), exp_q[fi].kind);
          exp_q.delete(fi);
        end
        seen_q.push_back('{int'(event_btn), int'(event_kind)});
        if (event_kind == 2'b11) long_seen++;
      end
      prev_stall = event_valid && !event_ready;
      prev_btn   = event_btn;
      prev_kind  = event_kind;
    end
  end

  // A tick must never land while a scan is still in progress.
  always @(negedge clk) begin
    if (rst && dut.tick && (dut.state == SC_SCAN)) begin
      total++;
      bad++;
      $display("FAIL tick_during_scan: got tick=1 in SCAN, required tick only in IDLE (t=%0t)", $time);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_btn_state"}, int'(btn_state), 0);
    check({tag, "_valid"}, int'(event_valid), 0);
    check({tag, "_btn"}, int'(event_btn), 0);
    check({tag, "_kind"}, int'(event_kind), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  int exp_long;

  initial begin
    logic [3:0] v;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Idle for 200 cycles: nothing may happen.
    repeat (25) begin
      run_period(4'b0000, 0);
      check("idle_valid", int'(event_valid), 0);
      check("idle_overflow", int'(overflow), 0);
    end

    // Clean press on button 2.
    seen_q.delete();
    valid_cycles = 0;
    repeat (5) run_period(4'b0100, 0);
    check("press_count", seen_q.size(), 1);
    if (seen_q.size() > 0) check("press_btn", seen_q[0].btn, 2);
    check("press_valid_cycles", valid_cycles, 1);
    repeat (4) run_period(4'b0000, 0);

    // Bounce on button 1: two differing samples, back, then one more.
    seen_q.delete();
    run_period(4'b0010, 0);
    run_period(4'b0010, 0);
    run_period(4'b0000, 0);
    run_period(4'b0010, 0);
    repeat (3) run_period(4'b0000, 0);
    check("bounce_events", seen_q.size(), 0);

    // Long press on button 0, then release.
    seen_q.delete();
    long_seen = 0;
    repeat (10) run_period(4'b0001, 0);
    repeat (4) run_period(4'b0000, 0);
`ifdef BTN_LONG_PRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif
    check("long_count", long_seen, exp_long);
    check("long_seq_len", seen_q.size(), 2 + exp_long);

    // Arbitration with backpressure: buttons 0, 1, 3 in the same sample.
    seen_q.delete();
    repeat (4) run_period(4'b1011, 1);
    check("arb_valid", int'(event_valid), 1);
    check("arb_head_btn", int'(event_btn), 0);
    check("arb_head_kind", int'(event_kind), 1);
    repeat (2) run_period(4'b1011, 0);
    check("arb_count", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      check("arb_order0", seen_q[0].btn, 0);
      check("arb_order1", seen_q[1].btn, 1);
      check("arb_order2", seen_q[2].btn, 3);
    end
    repeat (4) run_period(4'b0000, 0);

    // Overflow: register holds button 0 while slot 3 gets press then release.
    check("pre_overflow", int'(overflow), 0);
    seen_q.delete();
    repeat (3) run_period(4'b1001, 1);
    repeat (4) run_period(4'b0001, 1);
    check("overflow_set", int'(overflow), 1);
    check("ovf_valid", int'(event_valid), 1);
    check("ovf_btn", int'(event_btn), 0);
    check("ovf_kind", int'(event_kind), 1);
    // The overwritten press on button 3 is never delivered.
    foreach (exp_q[k]) begin
      if (exp_q[k].btn == 3) begin
        exp_q.delete(k);
        break;
      end
    end
    repeat (4) run_period(4'b0000, 0);
    if (seen_q.size() >= 2) begin
      check("ovf_first_btn", seen_q[0].btn, 0);
      check("ovf_first_kind", seen_q[0].kind, 1);
      check("ovf_second_btn", seen_q[1].btn, 3);
      check("ovf_second_kind", seen_q[1].kind, 2);
    end else begin
      check("ovf_delivered", seen_q.size(), 2);
    end
    repeat (2) run_period(4'b0000, 0);
    check("overflow_sticky", int'(overflow), 1);

    // Asynchronous reset in the middle of a scan.
    repeat (3) run_period(4'b0110, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_state", int'(btn_state), 4'b0010);
    rst = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    model_reset();
    seen_q.delete();
    btn_in = '0;
    event_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with short backpressure bursts.
    v = '0;
    repeat (40) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
      run_period(v, 2);
    end
    repeat (6) run_period(4'b0000, 0);
    check("random_overflow", int'(overflow), 0);
    check("leftover_expected", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
